twiddle_sequencer: RTL and testbench
====================================

# twiddle_sequencer

Address sequencer and alignment controller for the 64-point twiddle ROM in one radix-2^2 SDF FFT stage. It counts butterfly-output samples, maps each sample index to its twiddle factor number, and drives the ROM address. It then re-times the sample-valid strobe so the complex multiplier sees valid, bypass and frame-end flags in the same cycle as the matching ROM output. It sits between the stage's BF2II butterfly output and the twiddle ROM/complex multiplier pair.

## Interface

- TW_FF, 1, ROM output-register setting; must equal the TW_FF of the twiddle ROM instance (0 = combinational ROM, 1 = registered ROM)
- clock  input  1  master clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- bf_en  input  1  butterfly output sample valid, one sample per cycle when high, gaps allowed
- clear  input  1  synchronous restart: flush counter and pipeline
- tw_addr  output  6  twiddle factor number to ROM addr
- mul_en  output  1  ROM data and delayed butterfly sample valid at multiplier
- mul_bypass  output  1  twiddle is W^0; multiplier passes data through (qualified by mul_en)
- frame_last  output  1  pulse with mul_en of sample 63 of a frame
- frame_active  output  1  high while a frame is partially received (sample counter != 0)

## Operation

- Sample counter cnt[5:0]: increments by 1 on each cycle with bf_en=1, 63 wraps to 0, holds when bf_en=0; no frame-start input, frames are back-to-back multiples of 64 samples.
- Index split: m = cnt[5:4] (quarter), k = cnt[3:0].
- Address map (quarter order {0,2,1,3}): m=0 -> 0; m=1 -> 2k; m=2 -> k; m=3 -> 3k. Max value 45, fits 6 bits unsigned, no wrap. Only entries 0-30 (even above 16), 1-15 and multiples of 3 up to 45 are ever addressed.
- tw_addr register: loads map(cnt) on cycles with bf_en=1; holds otherwise.
- Bypass: byp = (m==0) or (k==0), computed from the same cnt as the address.
- Alignment pipeline: {bf_en, byp, cnt==63} shift through 1+TW_FF stages. The last stage drives mul_en, mul_bypass (ANDed with the valid bit), and frame_last (ANDed with the valid bit).
- frame_active = (cnt != 0).
- clear=1: cnt <- 0 and all pipeline valid bits <- 0. tw_addr <- 0. A bf_en in the same cycle is discarded, so clear has priority. Outputs are low from the next cycle.
- reset_n low, at any time including mid-frame: all state cleared immediately. Counting restarts at sample 0 after release.

## Timing

- Reset values: tw_addr=0, mul_en=0, mul_bypass=0, frame_last=0, frame_active=0.
- bf_en high in cycle T with cnt=c:
  - tw_addr=map(c) from T+1.
  - ROM data valid at T+1+TW_FF.
  - mul_en, mul_bypass and frame_last are valid at T+1+TW_FF.
- Latency from bf_en to mul_en: 2 cycles with TW_FF=1, 1 cycle with TW_FF=0. Gaps in bf_en propagate unchanged.
- Throughput: one sample per cycle, no backpressure, no stall.
- frame_active changes at T+1 after the counting edge. It falls in the cycle after sample 63 is accepted.

## Test plan

- Contiguous frame, TW_FF=1, 64 cycles of bf_en.
  - tw_addr sequence: 0×16, then 0,2,4..30, then 0,1..15, then 0,3,6..45.
  - mul_en high from cycle 2 to 65.
  - mul_bypass high for samples 0-16, 32 and 48.
  - frame_last pulses once at cycle 65.
- Same stream with TW_FF=0: identical flags, 1 cycle earlier. Each tw_addr value is present in the cycle its mul_en is high.
- bf_en toggling 1,0,1,0 over 128 cycles:
  - tw_addr holds during gaps.
  - mul_en replicates the gap pattern 2 cycles later.
  - frame_last is seen after the 64th accepted sample.
- clear asserted with bf_en=1 at sample 40:
  - that sample is dropped.
  - pending mul_en pulses are flushed.
  - the next accepted sample maps to address 0 as sample 0, with frame_active=0 before it.
- reset_n pulsed low mid-frame (sample 20), asynchronously between edges: all outputs 0 immediately, and the next frame starts at cnt=0.
- Two back-to-back frames (128 samples): cnt wraps 63->0 without a bubble. frame_last fires at samples 63 and 127 only.

Source files
------------

// File: rtl/twiddle_sequencer_if.sv
// Handshake bundle between the BF2II output, twiddle ROM and complex multiplier.
// master drives bf_en/clear; slave (the sequencer) drives ROM address and flags.
interface twiddle_sequencer_if;
    logic       bf_en;
    logic       clear;
    logic [5:0] tw_addr;
    logic       mul_en;
    logic       mul_bypass;
    logic       frame_last;
    logic       frame_active;

    modport master (
        output bf_en, clear,
        input  tw_addr, mul_en, mul_bypass, frame_last, frame_active
    );

    modport slave (
        input  bf_en, clear,
        output tw_addr, mul_en, mul_bypass, frame_last, frame_active
    );
endinterface

// File: rtl/twiddle_sequencer.sv
// Twiddle ROM address sequencer and multiplier alignment for a 64-point R2^2 SDF stage.
// Ports: clock, reset_n (async, active low), bus (slave): bf_en/clear in; tw_addr and mul flags out.
module twiddle_sequencer #(
    parameter int TW_FF = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    twiddle_sequencer_if.slave  bus
);
    // One stage for the address register, plus one when the ROM registers its output.
    localparam int NS = 1 + TW_FF;

    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    addr_q, addr_d;
    logic [NS-1:0] vld_q, vld_d;
    logic [NS-1:0] byp_q, byp_d;
    logic [NS-1:0] last_q, last_d;

    logic [1:0] m;
    logic [3:0] k;
    logic [5:0] map_addr;
    logic       byp;

    // Quarter order {0,2,1,3}: m=1 uses 2k, m=2 uses k, m=3 uses 3k.
    always_comb begin
        m        = cnt_q[5:4];
        k        = cnt_q[3:0];
        map_addr = 6'd0;
        unique case (m)
            2'd0: map_addr = 6'd0;
            2'd1: map_addr = {1'b0, k, 1'b0};
            2'd2: map_addr = {2'b00, k};
            2'd3: map_addr = {2'b00, k} + {1'b0, k, 1'b0};
        endcase
        byp = (m == 2'd0) || (k == 4'd0);
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        // The alignment pipeline advances every cycle so gaps propagate.
        vld_d  = NS'({vld_q, bus.bf_en});
        byp_d  = NS'({byp_q, byp});
        last_d = NS'({last_q, cnt_q == 6'd63});
        if (bus.bf_en) begin
            cnt_d  = cnt_q + 6'd1;
            addr_d = map_addr;
        end
        // clear wins over a same-cycle bf_en.
        if (bus.clear) begin
            cnt_d  = 6'd0;
            addr_d = 6'd0;
            vld_d  = '0;
            byp_d  = '0;
            last_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= 6'd0;
            addr_q <= 6'd0;
            vld_q  <= '0;
            byp_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            vld_q  <= vld_d;
            byp_q  <= byp_d;
            last_q <= last_d;
        end
    end

    assign bus.tw_addr      = addr_q;
    assign bus.mul_en       = vld_q[NS-1];
    assign bus.mul_bypass   = vld_q[NS-1] & byp_q[NS-1];
    assign bus.frame_last   = vld_q[NS-1] & last_q[NS-1];
    assign bus.frame_active = (cnt_q != 6'd0);
endmodule

// File: tb/tb_twiddle_sequencer.sv
// Self-checking bench for twiddle_sequencer, both ROM settings side by side.
// Directed test-plan steps followed by random bf_en/clear traffic.
module tb_twiddle_sequencer;
    logic clock;
    logic reset_n;

    twiddle_sequencer_if bus1 ();
    twiddle_sequencer_if bus0 ();

    twiddle_sequencer #(.TW_FF(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    twiddle_sequencer #(.TW_FF(0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: sample index within frame, current address,
    // and sample index accepted one / two cycles ago (-1 = none).
    int n_mod;
    int exp_addr;
    int h1;
    int h2;
    int last_seen;

    function automatic int map_f(input int idx);
        int q;
        int kk;
        q  = idx / 16;
        kk = idx % 16;
        if (q == 0) return 0;
        else if (q == 1) return 2 * kk;
        else if (q == 2) return kk;
        else return 3 * kk;
    endfunction

    function automatic bit byp_f(input int idx);
        return (idx < 16) || (idx % 16 == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ff1_addr",   32'(bus1.tw_addr),      32'(exp_addr));
        chk("ff1_en",     32'(bus1.mul_en),       32'(h2 >= 0));
        chk("ff1_byp",    32'(bus1.mul_bypass),   32'(h2 >= 0 && byp_f(h2)));
        chk("ff1_last",   32'(bus1.frame_last),   32'(h2 == 63));
        chk("ff1_active", 32'(bus1.frame_active), 32'(n_mod != 0));
        chk("ff0_addr",   32'(bus0.tw_addr),      32'(exp_addr));
        chk("ff0_en",     32'(bus0.mul_en),       32'(h1 >= 0));
        chk("ff0_byp",    32'(bus0.mul_bypass),   32'(h1 >= 0 && byp_f(h1)));
        chk("ff0_last",   32'(bus0.frame_last),   32'(h1 == 63));
        chk("ff0_active", 32'(bus0.frame_active), 32'(n_mod != 0));
    endtask

    task automatic cycle(input bit bf, input bit clr);
        bus1.bf_en = bf;
        bus0.bf_en = bf;
        bus1.clear = clr;
        bus0.clear = clr;
        @(posedge clock);
        if (clr) begin
            h2       = -1;
            h1       = -1;
            n_mod    = 0;
            exp_addr = 0;
        end else begin
            h2 = h1;
            h1 = bf ? n_mod : -1;
            if (bf) begin
                exp_addr = map_f(n_mod);
                n_mod    = (n_mod + 1) % 64;
            end
        end
        #1;
        check_all();
        if (bus1.frame_last === 1'b1) last_seen++;
    endtask

    task automatic model_reset();
        n_mod    = 0;
        exp_addr = 0;
        h1       = -1;
        h2       = -1;
    endtask

    task automatic async_reset();
        bus1.bf_en = 1'b0;
        bus0.bf_en = 1'b0;
        bus1.clear = 1'b0;
        bus0.clear = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        bus1.bf_en = 1'b0;
        bus0.bf_en = 1'b0;
        bus1.clear = 1'b0;
        bus0.clear = 1'b0;
        model_reset();
        last_seen = 0;
        @(posedge clock);
        #1;
        check_all();
        #2 reset_n = 1'b1;

        // Contiguous frame.
        last_seen = 0;
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("frame1_last_count", 32'(last_seen), 32'd1);

        // Alternating bf_en, 128 cycles.
        last_seen = 0;
        for (int i = 0; i < 128; i++) cycle(i % 2 == 0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("toggle_last_count", 32'(last_seen), 32'd1);

        // clear with bf_en at sample 40.
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        // Asynchronous reset at sample 20.
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        // Two back-to-back frames.
        cycle(1'b0, 1'b1);
        last_seen = 0;
        for (int i = 0; i < 128; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("b2b_last_count", 32'(last_seen), 32'd2);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
